// File: rtl/rtl_dcnt_bk.sv
// Loadable countdown timer with Brent-Kung borrow network.
// Counts down in RUN, pulses expire on reaching zero, optional auto-reload.
module rtl_dcnt_bk #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         ld_valid,
   output logic         ld_ready,
   input  logic [N-1:0] ld_value,
   input  logic         ld_auto,
   input  logic         bin,
   input  logic         abort,
   output logic [N-1:0] counter,
   output logic         bout,
   output logic         expire,
   output logic         busy
);

   localparam int M  = N + 1;
   localparam int LG = $clog2(M);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       state_n;
   logic [N-1:0] reload;
   logic         auto_r;
   logic [N:0]   c;
   logic [N-1:0] counter_n;
   logic         bout_n;
   logic         ld_acc;
   logic         hit;
   logic         ld_zero;

   // Element 0 injects bin; element k propagates through ~counter[k-1].
   always_comb begin : bk
      logic [M-1:0] gg;
      logic [M-1:0] pp;
      gg        = '0;
      pp        = '0;
      gg[0]     = bin;
      pp[M-1:1] = ~counter;
      for (int l = 0; l < LG; l++) begin
         for (int i = (2 << l) - 1; i < M; i += (2 << l)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      for (int l = LG - 2; l >= 0; l--) begin
         for (int i = 3 * (1 << l) - 1; i < M; i += (2 << l)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
            pp[i] = pp[i] & pp[i - (1 << l)];
         end
      end
      c = gg;
   end

   assign counter_n = counter ^ c[N-1:0];
   assign bout_n    = c[N];
   assign ld_acc    = ld_valid & ld_ready;
   assign ld_zero   = (ld_value == '0);
   assign hit       = bin & (counter == {{(N-1){1'b0}}, 1'b1});

   always_ff @(posedge clk) begin
      if (!nrst) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE, DONE: if (ld_acc) state_n = ld_zero ? DONE : RUN;
            RUN:        if (hit && !auto_r) state_n = DONE;
            default:    state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      ld_ready = (state != RUN);
      busy     = (state == RUN);
   end

   // Abort freezes the count; expiry reloads or parks at zero.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         counter <= '0;
         reload  <= '0;
         auto_r  <= 1'b0;
         bout    <= 1'b0;
         expire  <= 1'b0;
      end else if (abort) begin
         expire <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (state != RUN) begin
            if (ld_acc) begin
               counter <= ld_value;
               reload  <= ld_value;
               auto_r  <= ld_auto;
               bout    <= 1'b0;
               expire  <= ld_zero;
            end
         end else if (bin) begin
            bout <= bout_n;
            if (hit) begin
               expire  <= 1'b1;
               counter <= auto_r ? reload : '0;
            end else begin
               counter <= counter_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtl_dcnt_bk.sv
// Bench for rtl_dcnt_bk: directed scenarios plus random traffic
// compared against an arithmetic timer model.
module tb_rtl_dcnt_bk;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         ld_valid = 1'b0;
   logic         ld_ready;
   logic [N-1:0] ld_value = '0;
   logic         ld_auto = 1'b0;
   logic         bin = 1'b0;
   logic         abort = 1'b0;
   logic [N-1:0] counter;
   logic         bout;
   logic         expire;
   logic         busy;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [N-1:0] m_cnt = '0;
   logic [N-1:0] m_rel = '0;
   logic         m_auto = 1'b0;
   logic         m_run = 1'b0;
   logic         m_exp = 1'b0;
   logic         m_bout = 1'b0;

   wire [N+3:0] obs = {counter, expire, ld_ready, busy, bout};
   wire [N+3:0] mdl = {m_cnt, m_exp, ~m_run, m_run, m_bout};

   rtl_dcnt_bk #(.N(N)) dut (
      .clk(clk),
      .nrst(nrst),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_value(ld_value),
      .ld_auto(ld_auto),
      .bin(bin),
      .abort(abort),
      .counter(counter),
      .bout(bout),
      .expire(expire),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!nrst) begin
         m_run = 0; m_cnt = '0; m_rel = '0;
         m_auto = 0; m_exp = 0; m_bout = 0;
      end else if (abort) begin
         m_run = 0; m_exp = 0;
      end else if (!m_run) begin
         m_exp = 0;
         if (ld_valid) begin
            m_cnt = ld_value; m_rel = ld_value;
            m_auto = ld_auto; m_bout = 0;
            if (ld_value == 0) m_exp = 1;
            else m_run = 1;
         end
      end else if (bin) begin
         m_bout = (m_cnt == 0);
         if (m_cnt == 1) begin
            m_exp = 1;
            if (m_auto) m_cnt = m_rel;
            else begin m_cnt = '0; m_run = 0; end
         end else begin
            m_cnt = m_cnt - 1;
            m_exp = 0;
         end
      end else begin
         m_exp = 0;
      end
   end

   task automatic test_reset();
      nrst = 0; ld_valid = 1; bin = 1; ld_value = 64'd7;
      repeat (2) @(negedge clk);
      nrst = 1; ld_valid = 0; bin = 0;
      checks++;
      if ({counter, expire, ld_ready, busy} !== {64'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset cnt=%h exp=%b rdy=%b busy=%b want 0 0 1 0",
                  counter, expire, ld_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (obs !== mdl) begin
         errors++; $display("FAIL reset_idle got %h want %h", obs, mdl);
      end
   endtask

   task automatic test_oneshot();
      int nexp = 0;
      ld_valid = 1; ld_value = 64'd5; ld_auto = 0; bin = 1;
      @(negedge clk);
      ld_valid = 0;
      checks++;
      if (counter !== 64'd5 || busy !== 1'b1) begin
         errors++; $display("FAIL oneshot_load cnt=%h busy=%b want 5 1", counter, busy);
      end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (expire) nexp++;
         checks++;
         if (counter !== ((k < 5) ? 64'(5 - k) : 64'd0) || expire !== (k == 5)) begin
            errors++;
            $display("FAIL oneshot_seq k=%0d cnt=%h exp=%b", k, counter, expire);
         end
         checks++;
         if (obs !== mdl) begin
            errors++; $display("FAIL oneshot_mdl got %h want %h", obs, mdl);
         end
      end
      checks++;
      if (nexp != 1 || ld_ready !== 1'b1) begin
         errors++; $display("FAIL oneshot_done expires=%0d rdy=%b want 1 1", nexp, ld_ready);
      end
   endtask

   task automatic test_autoreload();
      ld_valid = 1; ld_value = 64'd3; ld_auto = 1; bin = 1;
      @(negedge clk);
      ld_valid = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (counter !== 64'(3 - (k % 3)) || expire !== (k > 0 && k % 3 == 0)
             || busy !== 1'b1) begin
            errors++;
            $display("FAIL autoreload k=%0d cnt=%h exp=%b busy=%b", k, counter, expire, busy);
         end
         checks++;
         if (obs !== mdl) begin
            errors++; $display("FAIL autoreload_mdl got %h want %h", obs, mdl);
         end
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
   endtask

   task automatic test_wide_gated();
      logic [N-1:0] g;
      logic         b;
      ld_valid = 1; ld_value = '1; ld_auto = 0; bin = 0;
      @(negedge clk);
      ld_valid = 0;
      g = '1;
      for (int k = 0; k < 8; k++) begin
         b = (k % 2 == 0);
         bin = b;
         @(negedge clk);
         g = g - N'(b);
         checks++;
         if (counter !== g) begin
            errors++; $display("FAIL wide k=%0d got %h want %h", k, counter, g);
         end
         if (k == 0) begin
            checks++;
            if (counter !== 64'hFFFF_FFFF_FFFF_FFFE) begin
               errors++; $display("FAIL wide_first got %h want fffffffffffffffe", counter);
            end
         end
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
   endtask

   task automatic test_zero_load();
      ld_valid = 1; ld_value = '0; ld_auto = 0; bin = 1;
      @(negedge clk);
      checks++;
      if ({expire, counter, bout, ld_ready, busy} !== {1'b1, 64'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL zero_load exp=%b cnt=%h bout=%b rdy=%b busy=%b",
                  expire, counter, bout, ld_ready, busy);
      end
      ld_value = 64'd4;
      @(negedge clk);
      ld_valid = 0;
      checks++;
      if ({busy, counter, expire} !== {1'b1, 64'd4, 1'b0}) begin
         errors++;
         $display("FAIL done_reload busy=%b cnt=%h exp=%b want 1 4 0", busy, counter, expire);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== mdl) begin
            errors++; $display("FAIL done_count got %h want %h", obs, mdl);
         end
      end
      checks++;
      if (counter !== 64'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL done_end cnt=%h busy=%b want 0 0", counter, busy);
      end
   endtask

   task automatic test_abort_reset();
      bit found = 0;
      ld_valid = 1; ld_value = 64'd100; ld_auto = 0; bin = 1;
      @(negedge clk);
      ld_valid = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (counter == 64'd57) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL abort_reach cnt=%h want 39 (57)", counter);
      end
      abort = 1;
      @(negedge clk);
      abort = 0;
      checks++;
      if ({counter, busy, expire, ld_ready} !== {64'd57, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL abort cnt=%h busy=%b exp=%b rdy=%b want 57 0 0 1",
                  counter, busy, expire, ld_ready);
      end
      ld_valid = 1; ld_value = 64'd20;
      @(negedge clk);
      ld_valid = 0;
      repeat (3) @(negedge clk);
      nrst = 0;
      @(negedge clk);
      nrst = 1;
      checks++;
      if ({counter, busy, ld_ready} !== {64'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midrun_reset cnt=%h busy=%b rdy=%b want 0 0 1", counter, busy, ld_ready);
      end
   endtask

   task automatic test_back_to_back();
      ld_valid = 1; ld_value = 64'd2; ld_auto = 0; bin = 1;
      @(negedge clk);
      ld_value = 64'd3;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== mdl) begin
            errors++; $display("FAIL back_to_back k=%0d got %h want %h", k, obs, mdl);
         end
      end
      ld_valid = 0;
      abort = 1;
      @(negedge clk);
      abort = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         ld_valid = ($urandom_range(0, 9) < 3);
         ld_value = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                                : N'($urandom_range(0, 6));
         ld_auto  = $urandom_range(0, 1) == 1;
         bin      = ($urandom_range(0, 9) < 7);
         abort    = ($urandom_range(0, 49) == 0);
         nrst     = ($urandom_range(0, 99) != 0);
         @(negedge clk);
         checks++;
         if (obs !== mdl) begin
            errors++; $display("FAIL random k=%0d got %h want %h", k, obs, mdl);
         end
      end
      nrst = 1; ld_valid = 0; abort = 0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_wide_gated();
      test_zero_load();
      test_abort_reset();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
